// File: rtl/jt7759_rate_det.sv
// Recovers the JT7759 divby value from a sample strobe by timing it in 640 kHz cen ticks.
// Define JT7759_RATEDET_DBG_EN to add the period/nerr debug outputs.
module jt7759_rate_det #(
    parameter int LOCKN  = 2,
    parameter int MINDIV = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       strobe,
    output logic [5:0] divby,
    output logic       locked,
    output logic       err,
    output logic       stall
`ifdef JT7759_RATEDET_DBG_EN
    ,
    output logic [8:0] period,
    output logic [7:0] nerr
`endif
);

    localparam logic [9:0] PMIN    = 10'(4 * (MINDIV + 1));
    localparam logic [9:0] PMAX    = 10'd256;
    localparam logic [3:0] LOCKN_W = 4'(LOCKN);

    typedef enum logic [1:0] {IDLE, MEAS, LOCK} state_t;

    state_t     state, state_nxt;
    logic [8:0] cnt, cnt_nxt;
    logic [9:0] p;
    logic [5:0] d;
    logic       p_ok, timeout, lock_hit;
    logic [5:0] cand, cand_nxt, divby_nxt;
    logic [2:0] match, match_nxt;
    logic       locked_nxt, err_nxt, stall_nxt;

    // A cen coinciding with the strobe belongs to the period that ends here.
    assign p        = {1'b0, cnt} + {9'd0, cen};
    assign d        = p[7:2] - 6'd1;
    assign p_ok     = (p[1:0] == 2'b00) && (p >= PMIN) && (p <= PMAX);
    assign timeout  = (state != IDLE) && !strobe && cen && (cnt == 9'd510);
    assign lock_hit = (d == cand) ? (({1'b0, match} + 4'd1) >= LOCKN_W)
                                  : (LOCKN_W == 4'd1);
    assign cnt_nxt  = strobe ? 9'd0 : (cnt == 9'd511) ? cnt : cnt + {8'd0, cen};

    // NOTE: reset is synchronous, so it lives inside the clocked block and wins over a same-cycle strobe.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (strobe) state_nxt = MEAS;
            MEAS: begin
                if (timeout)                        state_nxt = IDLE;
                else if (strobe && p_ok && lock_hit) state_nxt = LOCK;
            end
            LOCK: begin
                if (timeout)                                 state_nxt = IDLE;
                else if (strobe && !(p_ok && d == divby))    state_nxt = MEAS;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every *_nxt gets a hold/default value first, so no path leaves a latch behind.
    always_comb begin
        cand_nxt   = cand;
        match_nxt  = match;
        divby_nxt  = divby;
        locked_nxt = locked;
        err_nxt    = 1'b0;
        stall_nxt  = 1'b0;
        case (state)
            MEAS: begin
                if (timeout) begin
                    stall_nxt  = 1'b1;
                    locked_nxt = 1'b0;
                    match_nxt  = '0;
                end else if (strobe) begin
                    if (!p_ok) begin
                        err_nxt   = 1'b1;
                        match_nxt = '0;
                    end else begin
                        if (d == cand) begin
                            match_nxt = match + 3'd1;
                        end else begin
                            cand_nxt  = d;
                            match_nxt = 3'd1;
                        end
                        if (lock_hit) begin
                            divby_nxt  = d;
                            locked_nxt = 1'b1;
                        end
                    end
                end
            end
            LOCK: begin
                if (timeout) begin
                    stall_nxt  = 1'b1;
                    locked_nxt = 1'b0;
                    match_nxt  = '0;
                end else if (strobe) begin
                    if (!p_ok) begin
                        err_nxt    = 1'b1;
                        locked_nxt = 1'b0;
                        match_nxt  = '0;
                    end else if (d != divby) begin
                        locked_nxt = 1'b0;
                        cand_nxt   = d;
                        match_nxt  = 3'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            cand   <= '0;
            match  <= '0;
            divby  <= '0;
            locked <= 1'b0;
            err    <= 1'b0;
            stall  <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            cand   <= cand_nxt;
            match  <= match_nxt;
            divby  <= divby_nxt;
            locked <= locked_nxt;
            err    <= err_nxt;
            stall  <= stall_nxt;
        end
    end

`ifdef JT7759_RATEDET_DBG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            period <= '0;
            nerr   <= '0;
        end else begin
            if (strobe && state != IDLE)
                period <= (p > 10'd511) ? 9'd511 : p[8:0];
            if (err_nxt && nerr != 8'hff)
                nerr <= nerr + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_jt7759_rate_det.sv
// Directed self-checking bench for jt7759_rate_det: expected post-strobe outputs go
// through a scoreboard queue and are compared one clk after each strobe.
module tb_jt7759_rate_det;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen = 1'b0;
    logic       strobe = 1'b0;
    logic [5:0] divby;
    logic       locked, err, stall;

    typedef struct packed {
        logic [5:0] divby;
        logic       locked;
        logic       err;
        logic       stall;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  exp;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    jt7759_rate_det #(.LOCKN(2), .MINDIV(9)) dut (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .strobe (strobe),
        .divby  (divby),
        .locked (locked),
        .err    (err),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t now_obs();
        obs_t o;
        o = {divby, locked, err, stall};
        return o;
    endfunction

    // Drive one clk; outputs are sampled 1 time unit after the edge.
    task automatic clk_step(input logic c, input logic s);
        cen    = c;
        strobe = s;
        @(posedge clk);
        #1;
        cen    = 1'b0;
        strobe = 1'b0;
    endtask

    task automatic gap(input int ncen, input int div, output int pulses);
        pulses = 0;
        for (int i = 0; i < ncen; i++) begin
            for (int j = 0; j < div - 1; j++) begin
                clk_step(1'b0, 1'b0);
                pulses += int'(err) + int'(stall);
            end
            clk_step(1'b1, 1'b0);
            pulses += int'(err) + int'(stall);
        end
    endtask

    // One strobe period of ncen cen ticks; swc puts the last cen on the strobe clk.
    task automatic period(input string tag, input int ncen, input int div, input bit swc,
                          input logic [5:0] e_div, input logic e_lock, input logic e_err);
        int  pulses;
        sb_t item;
        gap(swc ? ncen - 1 : ncen, div, pulses);
        check({tag, " gap pulses"}, 32'(pulses), 32'd0);
        item.tag = tag;
        item.exp = {e_div, e_lock, e_err, 1'b0};
        sb.push_back(item);
        clk_step(swc, 1'b1);
        item = sb.pop_front();
        check(item.tag, 32'(now_obs()), 32'(item.exp));
    endtask

    initial begin
        int   pulses;
        int   st_pulses;
        logic lock_at_stall;

        // Reset, with a strobe landing in the last reset clk (must be ignored).
        repeat (2) @(posedge clk);
        #1;
        strobe = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        strobe = 1'b0;
        check("reset state", 32'(now_obs()), 32'd0);

        // Lock at divby 9: arm, first measure, match.
        period("t1 arm",   40, 16, 1'b0, 6'd0, 1'b0, 1'b0);
        period("t1 p40 a", 40, 16, 1'b0, 6'd0, 1'b0, 1'b0);
        period("t1 p40 b", 40, 16, 1'b0, 6'd9, 1'b1, 1'b0);

        // Switch to the slowest legal cadence.
        period("t2 p256 a", 256, 16, 1'b0, 6'd9,  1'b0, 1'b0);
        period("t2 p256 b", 256, 16, 1'b0, 6'd63, 1'b1, 1'b0);

        // Strobes stop: exactly one stall pulse, lock lost.
        st_pulses    = 0;
        lock_at_stall = 1'b1;
        for (int i = 0; i < 8400; i++) begin
            clk_step((i % 16) == 15, 1'b0);
            if (stall) begin
                st_pulses++;
                lock_at_stall = locked;
            end
        end
        check("stall pulse count", 32'(st_pulses), 32'd1);
        check("locked at stall", 32'(lock_at_stall), 32'd0);
        check("locked after stall", 32'(locked), 32'd0);

        // Re-arm, then relock only after the required matches.
        period("t3 rearm",  40, 16, 1'b0, 6'd63, 1'b0, 1'b0);
        period("t3 p40 a",  40, 16, 1'b0, 6'd63, 1'b0, 1'b0);
        period("t3 p40 b",  40, 16, 1'b0, 6'd9,  1'b1, 1'b0);

        // Reset mid-period while locked, strobe in the same clk.
        gap(12, 16, pulses);
        check("pre-reset gap pulses", 32'(pulses), 32'd0);
        rst    = 1'b1;
        strobe = 1'b1;
        cen    = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        strobe = 1'b0;
        cen    = 1'b0;
        check("mid-period reset", 32'(now_obs()), 32'd0);

        // First strobe after reset only arms; then invalid periods.
        period("t4 arm no err", 36, 16, 1'b0, 6'd0, 1'b0, 1'b0);
        period("t4 p36 short",  36, 16, 1'b0, 6'd0, 1'b0, 1'b1);
        period("t4 p42 odd",    42, 16, 1'b0, 6'd0, 1'b0, 1'b1);
        period("t4 p260 long", 260, 16, 1'b0, 6'd0, 1'b0, 1'b1);

        // cen every clk, strobe shares a cen: p = 100 -> divby 24.
        period("t5 p100 a", 100, 1, 1'b1, 6'd0,  1'b0, 1'b0);
        period("t5 p100 b", 100, 1, 1'b1, 6'd24, 1'b1, 1'b0);
        clk_step(1'b1, 1'b0);
        check("t5 hold", 32'(now_obs()), 32'({6'd24, 1'b1, 1'b0, 1'b0}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
